// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS modulation core.
package dds_pkg;

    typedef enum logic [1:0] {
        SIG_SINE   = 2'd0,
        SIG_COSINE = 2'd1,
        SIG_SQUARE = 2'd2,
        SIG_SAW    = 2'd3
    } signal_sel_t;

    typedef enum logic [1:0] {
        MOD_ASK  = 2'd0,
        MOD_FSK  = 2'd1,
        MOD_BPSK = 2'd2,
        MOD_LFSR = 2'd3
    } mod_sel_t;

    // Symbol LFSR: x^5 + x^3 + 1, Fibonacci form, feedback from bits 4 and 2.
    localparam int               LFSR_W      = 5;
    localparam logic [LFSR_W-1:0] LFSR_SEED  = 5'b00001;
    localparam int               LFSR_TAP_HI = 4;
    localparam int               LFSR_TAP_LO = 2;

    // Largest positive two's complement sample of the given width.
    function automatic int sample_max(input int data_w);
        return (1 << (data_w - 1)) - 1;
    endfunction

    // Most negative two's complement sample of the given width.
    function automatic int sample_min(input int data_w);
        return -(1 << (data_w - 1));
    endfunction

endpackage

// File: rtl/dds_wave_gen.sv
// Turns a phase word into the selected waveform, registered by one cycle.
// Owns the sine table; cosine reuses it with a quarter-turn phase offset.
module dds_wave_gen
    import dds_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int PHASE_W    = 32,
    parameter int LUT_ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PHASE_W-1:0]       phase,
    input  signal_sel_t              signal_sel,
    output logic signed [DATA_W-1:0] wave
);

    localparam int LUT_DEPTH = 1 << LUT_ADDR_W;
    localparam logic signed [DATA_W-1:0] MAX_S = DATA_W'(sample_max(DATA_W));
    localparam logic signed [DATA_W-1:0] MIN_S = DATA_W'(sample_min(DATA_W));
    localparam logic [PHASE_W-1:0] QUARTER_TURN = {2'b01, {(PHASE_W-2){1'b0}}};

    // Table entry from Bhaskara's rational sine approximation, evaluated at
    // elaboration. Peak is exactly +/-MAX, so MIN never appears in the table.
    function automatic logic signed [DATA_W-1:0] sine_entry(input int idx);
        longint half;
        longint x;
        longint u;
        longint num;
        longint den;
        longint mag;
        half = longint'(LUT_DEPTH / 2);
        x    = (idx < LUT_DEPTH / 2) ? longint'(idx) : longint'(idx - LUT_DEPTH / 2);
        u    = x * (half - x);
        num  = longint'(sample_max(DATA_W)) * 16 * u;
        den  = 5 * half * half - 4 * u;
        mag  = (num + den / 2) / den;
        return (idx < LUT_DEPTH / 2) ? DATA_W'(mag) : DATA_W'(-mag);
    endfunction

    logic signed [DATA_W-1:0] sine_lut [LUT_DEPTH];

    for (genvar i = 0; i < LUT_DEPTH; i++) begin : g_lut
        assign sine_lut[i] = sine_entry(i);
    end

    logic [PHASE_W-1:0]       cos_phase;
    logic [LUT_ADDR_W-1:0]    sine_addr;
    logic [LUT_ADDR_W-1:0]    cos_addr;
    logic signed [DATA_W-1:0] wave_d;
    logic signed [DATA_W-1:0] wave_q;
    logic                     unused_low_bits;

    assign unused_low_bits = ^{phase[PHASE_W-DATA_W-1:0], cos_phase[PHASE_W-LUT_ADDR_W-1:0]};

    // Select the waveform value for the current phase.
    always_comb begin
        cos_phase = phase + QUARTER_TURN;
        sine_addr = phase[PHASE_W-1 -: LUT_ADDR_W];
        cos_addr  = cos_phase[PHASE_W-1 -: LUT_ADDR_W];
        wave_d    = '0;
        case (signal_sel)
            SIG_SINE:   wave_d = sine_lut[sine_addr];
            SIG_COSINE: wave_d = sine_lut[cos_addr];
            SIG_SQUARE: wave_d = phase[PHASE_W-1] ? MIN_S : MAX_S;
            SIG_SAW:    wave_d = {~phase[PHASE_W-1], phase[PHASE_W-2 -: DATA_W-1]};
            default:    wave_d = '0;
        endcase
    end

    // Register the waveform so the LUT read sits in its own pipeline stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            wave_q <= '0;
        end else begin
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/dds_mod_core.sv
// DDS modulation core: two phase accumulators, symbol LFSR, modulation
// select and a sampler-triggered capture stage for the DAC/scope path.
module dds_mod_core
    import dds_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int PHASE_W    = 32,
    parameter int LUT_ADDR_W = 10,
    parameter int SYM_DIV_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     sampler,
    input  logic [PHASE_W-1:0]       tuning_word0,
    input  logic [PHASE_W-1:0]       tuning_word1,
    input  logic [SYM_DIV_W-1:0]     symbol_div,
    input  logic [1:0]               signal_sel,
    input  logic [1:0]               modulation_sel,
    output logic signed [DATA_W-1:0] mod_signal_out,
    output logic signed [DATA_W-1:0] original_signal,
    output logic                     lfsr_bit,
    output logic                     sample_valid
);

    localparam logic signed [DATA_W-1:0] MAX_S = DATA_W'(sample_max(DATA_W));
    localparam logic signed [DATA_W-1:0] MIN_S = DATA_W'(sample_min(DATA_W));

    signal_sel_t sig_sel;
    mod_sel_t    mod_sel;

    assign sig_sel = signal_sel_t'(signal_sel);
    assign mod_sel = mod_sel_t'(modulation_sel);

    logic [PHASE_W-1:0]       acc0_q, acc0_d;
    logic [PHASE_W-1:0]       acc1_q, acc1_d;
    logic                     sampler_meta_q, sampler_sync_q, sampler_prev_q;
    logic                     tick;
    logic [SYM_DIV_W-1:0]     count_q, count_d;
    logic [SYM_DIV_W-1:0]     limit_m1;
    logic [LFSR_W-1:0]        lfsr_q, lfsr_d;
    logic signed [DATA_W-1:0] orig_q, orig_d;
    logic signed [DATA_W-1:0] mod_q, mod_d;
    logic                     valid_q, valid_d;
    logic signed [DATA_W-1:0] w0, w1;
    logic signed [DATA_W-1:0] neg_w0;
    logic signed [DATA_W-1:0] mod_result;

    dds_wave_gen #(
        .DATA_W     (DATA_W),
        .PHASE_W    (PHASE_W),
        .LUT_ADDR_W (LUT_ADDR_W)
    ) u_wave0 (
        .clk        (clk),
        .reset      (reset),
        .phase      (acc0_q),
        .signal_sel (sig_sel),
        .wave       (w0)
    );

    dds_wave_gen #(
        .DATA_W     (DATA_W),
        .PHASE_W    (PHASE_W),
        .LUT_ADDR_W (LUT_ADDR_W)
    ) u_wave1 (
        .clk        (clk),
        .reset      (reset),
        .phase      (acc1_q),
        .signal_sel (sig_sel),
        .wave       (w1)
    );

    // Phase accumulators advance together and wrap naturally.
    always_comb begin
        acc0_d = acc0_q;
        acc1_d = acc1_q;
        if (en) begin
            acc0_d = acc0_q + tuning_word0;
            acc1_d = acc1_q + tuning_word1;
        end
    end

    // A sample tick is the first clock that sees the synchronised sampler high.
    assign tick = sampler_sync_q & ~sampler_prev_q;

    // Apply the selected modulation using the bit that was current before any step.
    always_comb begin
        neg_w0     = (w0 == MIN_S) ? MAX_S : -w0;
        mod_result = w0;
        case (mod_sel)
            MOD_ASK:  mod_result = lfsr_q[0] ? w0 : '0;
            MOD_FSK:  mod_result = lfsr_q[0] ? w1 : w0;
            MOD_BPSK: mod_result = lfsr_q[0] ? neg_w0 : w0;
            MOD_LFSR: mod_result = lfsr_q[0] ? MAX_S : MIN_S;
            default:  mod_result = w0;
        endcase
    end

    // Count ticks per symbol and step the LFSR at the end of each symbol.
    always_comb begin
        limit_m1 = (symbol_div == '0) ? '0 : symbol_div - SYM_DIV_W'(1);
        count_d  = count_q;
        lfsr_d   = lfsr_q;
        if (tick) begin
            if (count_q == limit_m1) begin
                count_d = '0;
                lfsr_d  = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]};
            end else begin
                count_d = count_q + SYM_DIV_W'(1);
            end
        end
    end

    // Capture both samples on a tick and hold them until the next one.
    always_comb begin
        orig_d  = orig_q;
        mod_d   = mod_q;
        valid_d = tick;
        if (tick) begin
            orig_d = w0;
            mod_d  = mod_result;
        end
    end

    // All core state, including the sampler synchroniser, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc0_q         <= '0;
            acc1_q         <= '0;
            sampler_meta_q <= 1'b0;
            sampler_sync_q <= 1'b0;
            sampler_prev_q <= 1'b0;
            count_q        <= '0;
            lfsr_q         <= LFSR_SEED;
            orig_q         <= '0;
            mod_q          <= '0;
            valid_q        <= 1'b0;
        end else begin
            acc0_q         <= acc0_d;
            acc1_q         <= acc1_d;
            sampler_meta_q <= sampler;
            sampler_sync_q <= sampler_meta_q;
            sampler_prev_q <= sampler_sync_q;
            count_q        <= count_d;
            lfsr_q         <= lfsr_d;
            orig_q         <= orig_d;
            mod_q          <= mod_d;
            valid_q        <= valid_d;
        end
    end

    assign mod_signal_out  = mod_q;
    assign original_signal = orig_q;
    assign lfsr_bit        = lfsr_q[0];
    assign sample_valid    = valid_q;

endmodule

// File: doc/dds_mod_core.md
# dds_mod_core

Parametrised modulation core for the DDS signal path. It owns two phase accumulators (carrier f0 and FSK carrier f1) and a symbol-rate LFSR, and generates sine, cosine, square and sawtooth waveforms internally. It applies ASK (on-off), FSK, BPSK or raw-LFSR modulation to the selected waveform. On each rising edge of the slow `sampler` signal it captures the modulated and unmodulated samples into registered outputs for the DAC/scope path.

## Interface
- `DATA_W`, 12: sample width, signed two's complement
- `PHASE_W`, 32: phase accumulator width
- `LUT_ADDR_W`, 10: sine LUT address width (top bits of phase)
- `SYM_DIV_W`, 16: width of symbol divider
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `en`  in  1  advance phase accumulators when high
- `sampler`  in  1  slow sample clock, asynchronous level
- `tuning_word0`  in  PHASE_W  f0 phase increment
- `tuning_word1`  in  PHASE_W  f1 phase increment (FSK mark)
- `symbol_div`  in  SYM_DIV_W  sample ticks per LFSR symbol; 0 treated as 1
- `signal_sel`  in  2  0 sine, 1 cosine, 2 square, 3 sawtooth
- `modulation_sel`  in  2  0 ASK, 1 FSK, 2 BPSK, 3 LFSR
- `mod_signal_out`  out  DATA_W  modulated sample
- `original_signal`  out  DATA_W  unmodulated selected waveform (f0)
- `lfsr_bit`  out  1  current symbol bit
- `sample_valid`  out  1  one-cycle pulse when outputs update

## Operation
- Constants: MAX = 2^(DATA_W-1)-1, MIN = -2^(DATA_W-1).
- Accumulators: when `en`=1, acc0 += tuning_word0 and acc1 += tuning_word1 every cycle, both wrapping modulo 2^PHASE_W. When `en`=0, both hold.
- Waveforms derived from phase p:
  - sine: LUT indexed by p[top LUT_ADDR_W], amplitude ±MAX; MIN is never produced.
  - cosine: sine of p + 2^(PHASE_W-2).
  - square: MAX if p MSB = 0, else MIN.
  - saw: p[top DATA_W] with MSB inverted, so phase 0 gives MIN.
- Waveform W0 is computed from acc0 and W1 from acc1, using the same `signal_sel`.
- Sampler path: 2-FF synchroniser, then an edge register. A rising edge produces an internal one-cycle tick. There is no tick while `sampler` is held high.
- On tick:
  - `original_signal` ← W0.
  - `mod_signal_out` ← mode result, computed with the pre-step `lfsr_bit`.
  - `sample_valid` pulses.
- Mode results:
  - ASK: W0 if `lfsr_bit`, else 0.
  - FSK: W1 if `lfsr_bit`, else W0.
  - BPSK: −W0 if `lfsr_bit`, else W0. Negation saturates, so −MIN = MAX.
  - LFSR: MAX if `lfsr_bit`, else MIN.
- Symbol counter:
  - Increments on each tick.
  - When count = max(symbol_div,1)−1, it clears and the LFSR steps.
  - A change of `symbol_div` takes effect at the next comparison. If count already exceeds the new limit, the counter wraps at 2^SYM_DIV_W; this is acceptable.
- LFSR:
  - 5-bit Fibonacci, x^5+x^3+1, period 31.
  - Step: lfsr ← {lfsr[3:0], lfsr[4]^lfsr[2]}.
  - `lfsr_bit` = lfsr[0]. The all-zero state is unreachable from the seed.

## Timing
- Reset values:
  - acc0 = acc1 = 0, lfsr = 5'b00001 (`lfsr_bit` = 1), symbol count 0.
  - Synchroniser and edge registers 0.
  - Both sample outputs 0, `sample_valid` 0.
- Reset mid-operation: all state returns to the reset values on the next edge. A sample in flight is discarded.
- Wave generator is registered (1 cycle), so a captured sample reflects the accumulator value from the cycle before the tick.
- `sampler` rising edge (setup met) → `sample_valid` high exactly 3 clk cycles later, with outputs updated in the same cycle.
- If `sampler` is high when reset releases, a tick fires about 3 cycles after release (the synchroniser starts at 0).
- LFSR step and new `lfsr_bit` are visible the cycle after the tick. The sample captured on that tick used the old bit.
- Ticks closer than 4 clk cycles apart are not supported.
- Outputs hold between ticks. Changing `signal_sel` or `modulation_sel` only affects the next captured sample.

## Structure
- Package `dds_pkg` holds:
  - enums `signal_sel_t` and `mod_sel_t`
  - LFSR seed and tap constants
  - a MAX/MIN helper function of DATA_W
- Sub-module `dds_wave_gen` (phase in, selected registered waveform out, owns the sine LUT) is instantiated twice, for acc0 and acc1.
- Sampler synchroniser and edge detect stay inline.

## Test plan
- Reset: hold `reset` 5 cycles with `sampler` toggling → all outputs 0, `lfsr_bit`=1, no `sample_valid`.
- Tick timing:
  - Single `sampler` rise → exactly one `sample_valid` pulse, 3 cycles later.
  - `sampler` held high for 100 cycles → no further pulses.
- BPSK saturation: tuning_word0=0, saw, BPSK, after reset → `original_signal`=−2048, `mod_signal_out`=2047.
- LFSR sequence: mode LFSR, symbol_div=1, 62 ticks:
  - `lfsr_bit` matches the reference polynomial model and has period 31.
  - Outputs take only 2047 or −2048.
- Symbol divider: symbol_div=4 → `lfsr_bit` changes only after every 4th tick. symbol_div=0 → changes every tick.
- Accumulator and FSK:
  - en=0 → outputs constant across ticks.
  - tuning_word0=2^31, square, en=1 → consecutive-cycle samples alternate 2047/−2048.
  - FSK with tuning_word1=0, `lfsr_bit`=1 → `mod_signal_out` equals W1 at phase 0.
